crubits_bank: RTL and testbench

Parametrised CRU output-bit bank for the TI-99/4A expansion interface, generalising the fixed 4-bit CRU latch to NUM_BITS bits. It samples the TI CRU bus (ti_cru_clk, addr, ti_cru_out) into the local clock domain and detects CRU write strobes on the falling edge of ti_cru_clk. It then updates an addressed bit register, with optional self-clearing pulse bits and an optional CRU read-back path. It sits between the TI bus pins and the card's control logic (ROM enable, reset lines, handshake flags).

---
 rtl/crubits_bank.sv | 136 +++++++++++++
 tb/tb_crubits_bank.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crubits_bank.sv
// crubits_bank: parametrised CRU output-bit bank for the TI-99/4A expansion bus.
// The TI CRU strobe, address and data are synchronised into clk, a write is
// committed on the falling edge of ti_cru_clk, and the addressed bit is updated.
// Bits selected in PULSE_MASK self-clear PULSE_LEN cycles after a write of 1.
// Optional feature macro: CRUBITS_READBACK_EN enables the combinational CRUIN
// read-back path; without it ti_cru_in and cru_in_oe are tied low.
module crubits_bank #(
   parameter int                  NUM_BITS   = 4,
   parameter logic [0:NUM_BITS-1] RESET_VAL  = {NUM_BITS{1'b0}},
   parameter logic [0:NUM_BITS-1] PULSE_MASK = {NUM_BITS{1'b0}},
   parameter int                  PULSE_LEN  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [0:3]            cru_base,
   input  logic                  ti_cru_clk,
   input  logic [0:14]           addr,
   input  logic                  ti_cru_out,
   output logic [0:NUM_BITS-1]   bits,
   output logic                  wr_strobe,
   output logic [6:0]            wr_index,
   output logic                  ti_cru_in,
   output logic                  cru_in_oe
);

   localparam int CW = $clog2(PULSE_LEN + 1);
   localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_LEN);

   // Synchronised copies of the asynchronous TI bus signals
   logic          cru_clk_s1, cru_clk_s2, cru_clk_s3;
   logic [0:14]   addr_s1, addr_s2;
   logic          cru_out_s1, cru_out_s2;

   // Write decode
   logic          fall;
   logic [6:0]    idx_s2;
   logic          hit;
   logic [0:NUM_BITS-1] wr_sel;

   // Per-bit pulse down-counters (stay zero for non-pulse bits)
   logic [CW-1:0] cnt [NUM_BITS];

   // Two-flop synchronisers; the strobe chain resets high so reset never looks like a fall
   always_ff @(posedge clk) begin
      if (reset) begin
         cru_clk_s1 <= 1'b1;
         cru_clk_s2 <= 1'b1;
         cru_clk_s3 <= 1'b1;
         addr_s1    <= '0;
         addr_s2    <= '0;
         cru_out_s1 <= 1'b0;
         cru_out_s2 <= 1'b0;
      end else begin
         cru_clk_s1 <= ti_cru_clk;
         cru_clk_s2 <= cru_clk_s1;
         cru_clk_s3 <= cru_clk_s2;
         addr_s1    <= addr;
         addr_s2    <= addr_s1;
         cru_out_s1 <= ti_cru_out;
         cru_out_s2 <= cru_out_s1;
      end
   end

   // addr_s2 and cru_out_s2 are aligned with cru_clk_s2, so they are the values
   // that were stable just before the falling edge
   assign fall   = cru_clk_s3 & ~cru_clk_s2;
   assign idx_s2 = addr_s2[8:14];
   assign hit    = fall
                 && (addr_s2[0:3] == 4'b0001)
                 && (addr_s2[4:7] == cru_base)
                 && (32'(idx_s2) < NUM_BITS);

   // One-hot select of the bit being written this cycle
   always_comb begin
      wr_sel = '0;
      for (int i = 0; i < NUM_BITS; i++) begin
         if (hit && (idx_s2 == 7'(i))) wr_sel[i] = 1'b1;
      end
   end

   // Bit registers and pulse counters; a write in the expiry cycle overrides the expiry
   always_ff @(posedge clk) begin
      if (reset) begin
         bits <= RESET_VAL;
         for (int i = 0; i < NUM_BITS; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_BITS; i++) begin
            if (wr_sel[i]) begin
               bits[i] <= cru_out_s2;
               if (PULSE_MASK[i]) cnt[i] <= cru_out_s2 ? PULSE_LOAD : '0;
            end else if (PULSE_MASK[i] && (cnt[i] != '0)) begin
               cnt[i] <= cnt[i] - 1'b1;
               if (cnt[i] == CW'(1)) bits[i] <= 1'b0;
            end
         end
      end
   end

   // Write strobe and last-written offset
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_strobe <= 1'b0;
         wr_index  <= '0;
      end else begin
         wr_strobe <= hit;
         if (hit) wr_index <= idx_s2;
      end
   end

`ifdef CRUBITS_READBACK_EN
   // Read-back decodes the raw bus: the TI samples CRUIN inside its own cycle
   logic [6:0] rd_idx;
   logic       rd_hit;
   logic       rd_bit;

   assign rd_idx = addr[8:14];
   assign rd_hit = (addr[0:3] == 4'b0001)
                && (addr[4:7] == cru_base)
                && (32'(rd_idx) < NUM_BITS);

   // Read mux over the bit bank
   always_comb begin
      rd_bit = 1'b0;
      for (int i = 0; i < NUM_BITS; i++) begin
         if (rd_idx == 7'(i)) rd_bit = bits[i];
      end
   end

   assign cru_in_oe = rd_hit;
   assign ti_cru_in = rd_hit & rd_bit;
`else
   assign cru_in_oe = 1'b0;
   assign ti_cru_in = 1'b0;
`endif

endmodule

// File: tb/tb_crubits_bank.sv
// tb_crubits_bank: self-checking bench for crubits_bank (4 bits, reset 1010,
// bit 1 is a pulse bit of length 8). Committed writes are predicted into a
// queue and checked against each wr_strobe.
module tb_crubits_bank;

   localparam int                NB     = 4;
   localparam logic [0:NB-1]     RST_V  = 4'b1010;
   localparam logic [0:NB-1]     P_MASK = 4'b0100;   // mask[1] set: bit 1 pulses
   localparam int                P_LEN  = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [0:3]    cru_base = 4'h2;
   logic          ti_cru_clk = 1'b1;
   logic [0:14]   addr = '0;
   logic          ti_cru_out = 1'b0;
   logic [0:NB-1] bits;
   logic          wr_strobe;
   logic [6:0]    wr_index;
   logic          ti_cru_in;
   logic          cru_in_oe;

   int total = 0;
   int bad   = 0;

   logic [7:0]    exp_q[$];          // {data, idx}
   logic [0:NB-1] model_bits = RST_V;
   logic          hist[64];

   crubits_bank #(
      .NUM_BITS(NB), .RESET_VAL(RST_V), .PULSE_MASK(P_MASK), .PULSE_LEN(P_LEN)
   ) dut (
      .clk(clk), .reset(reset), .cru_base(cru_base), .ti_cru_clk(ti_cru_clk),
      .addr(addr), .ti_cru_out(ti_cru_out), .bits(bits), .wr_strobe(wr_strobe),
      .wr_index(wr_index), .ti_cru_in(ti_cru_in), .cru_in_oe(cru_in_oe)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required finish before 200000");
      $fatal(1);
   end

   // TI address word: A0..A3 = top nibble, A4..A7 = base, A8..A14 = bit offset
   function automatic logic [14:0] make_addr(input logic [3:0] top, input logic [3:0] base,
                                             input logic [6:0] idx);
      return {top, base, idx};
   endfunction

   // scoreboard: every strobe must match the oldest predicted write
   always @(negedge clk) begin
      if (!reset && wr_strobe) begin
         logic [7:0] e;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_strobe: wr_index=%0d, required no strobe", wr_index);
         end else begin
            e = exp_q.pop_front();
            if (wr_index !== e[6:0]) begin
               bad++;
               $display("FAIL strobe_index: got %0d, required %0d", wr_index, e[6:0]);
            end
            total++;
            if (bits[int'(e[6:0])] !== e[7]) begin
               bad++;
               $display("FAIL strobe_bit: bits[%0d]=%b, required %b", e[6:0], bits[int'(e[6:0])], e[7]);
            end
         end
      end
   end

   // driver: one CRU write with 2 clk setup, 3 clk low and 2 clk high afterwards
   task automatic cru_write(input logic [3:0] top, input logic [3:0] base, input logic [6:0] idx,
                            input logic data, input bit accept);
      @(posedge clk); #1;
      addr = make_addr(top, base, idx);
      ti_cru_out = data;
      repeat (2) @(posedge clk);
      #1;
      ti_cru_clk = 1'b0;
      if (accept) begin
         exp_q.push_back({data, idx});
         model_bits[int'(idx)] = data;
      end
      repeat (3) @(posedge clk);
      #1;
      ti_cru_clk = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   // driver: write 1 to pulse bit 1, optionally a second write launched after edge second_k;
   // hist[k] holds bits[1] after edge k counted from the first low drive
   task automatic pulse_seq(input int second_k, input logic second_data, input int ncyc);
      @(posedge clk); #1;
      addr = make_addr(4'h1, 4'h2, 7'd1);
      ti_cru_out = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      ti_cru_clk = 1'b0;
      exp_q.push_back({1'b1, 7'd1});
      for (int k = 1; k < ncyc; k++) begin
         @(posedge clk); #1;
         if (k == 3) begin
            ti_cru_clk = 1'b1;
            if (second_k > 0) ti_cru_out = second_data;
         end
         if (second_k > 0 && k == second_k) begin
            ti_cru_clk = 1'b0;
            exp_q.push_back({second_data, 7'd1});
         end
         if (second_k > 0 && k == second_k + 4) ti_cru_clk = 1'b1;
         @(negedge clk);
         hist[k] = bits[1];
      end
      ti_cru_clk = 1'b1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      total++;
      if (bits !== 4'b1010) begin
         bad++; $display("FAIL reset_bits: got %b, required 1010", bits);
      end
      total++;
      if (wr_strobe !== 1'b0) begin
         bad++; $display("FAIL reset_strobe: got %b, required 0", wr_strobe);
      end
      total++;
      if (wr_index !== 7'd0) begin
         bad++; $display("FAIL reset_index: got %0d, required 0", wr_index);
      end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         total++;
         if (wr_strobe !== 1'b0) begin
            bad++; $display("FAIL reset_quiet: cycle %0d strobe=%b, required 0", c, wr_strobe);
         end
      end
   endtask

   task automatic test_basic_write;
      // clear bit 2 first so the timed write of 1 is visible
      cru_write(4'h1, 4'h2, 7'd2, 1'b0, 1'b1);
      @(posedge clk); #1;
      addr = make_addr(4'h1, 4'h2, 7'd2);
      ti_cru_out = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      ti_cru_clk = 1'b0;
      exp_q.push_back({1'b1, 7'd2});
      for (int e = 1; e <= 4; e++) begin
         @(posedge clk);
         @(negedge clk);
         total++;
         if (wr_strobe !== (e == 3)) begin
            bad++; $display("FAIL basic_strobe: edge %0d strobe=%b, required %b", e, wr_strobe, (e == 3));
         end
         total++;
         if (bits[2] !== (e >= 3)) begin
            bad++; $display("FAIL basic_latency: edge %0d bits[2]=%b, required %b", e, bits[2], (e >= 3));
         end
      end
      model_bits[2] = 1'b1;
      ti_cru_clk = 1'b1;
      total++;
      if (wr_index !== 7'd2) begin
         bad++; $display("FAIL basic_index: got %0d, required 2", wr_index);
      end
      total++;
      if (bits !== model_bits) begin
         bad++; $display("FAIL basic_others: got %b, required %b", bits, model_bits);
      end
      repeat (3) @(posedge clk);
   endtask

   task automatic test_rejected;
      cru_write(4'h1, 4'h3, 7'd0, 1'b0, 1'b0);   // other card base
      @(negedge clk);
      total++;
      if (bits !== model_bits) begin
         bad++; $display("FAIL reject_base: got %b, required %b", bits, model_bits);
      end
      cru_write(4'h1, 4'h2, 7'd5, 1'b1, 1'b0);   // offset beyond NUM_BITS
      @(negedge clk);
      total++;
      if (bits !== model_bits) begin
         bad++; $display("FAIL reject_range: got %b, required %b", bits, model_bits);
      end
      cru_write(4'h2, 4'h2, 7'd3, 1'b1, 1'b0);   // not a CRU space address
      @(negedge clk);
      total++;
      if (bits !== model_bits) begin
         bad++; $display("FAIL reject_top: got %b, required %b", bits, model_bits);
      end
   endtask

   task automatic test_pulse;
      int cnt_h;
      int first_h;
      int last_h;
      // single pulse: high after edges 3..10
      pulse_seq(0, 1'b0, 30);
      cnt_h = 0; first_h = -1; last_h = -1;
      for (int k = 1; k < 30; k++) if (hist[k]) begin
         cnt_h++; if (first_h < 0) first_h = k; last_h = k;
      end
      total++;
      if (cnt_h !== P_LEN || first_h !== 3 || last_h !== 10) begin
         bad++; $display("FAIL pulse_single: high=%0d first=%0d last=%0d, required 8 3 10", cnt_h, first_h, last_h);
      end
      // rewrite of 1 committed 5 cycles later: high for 5 + 8 cycles
      pulse_seq(5, 1'b1, 30);
      cnt_h = 0; last_h = -1;
      for (int k = 1; k < 30; k++) if (hist[k]) begin cnt_h++; last_h = k; end
      total++;
      if (cnt_h !== 13 || last_h !== 15) begin
         bad++; $display("FAIL pulse_extend: high=%0d last=%0d, required 13 15", cnt_h, last_h);
      end
      // write of 0 clears on its commit edge (edge 8)
      pulse_seq(5, 1'b0, 30);
      total++;
      if (hist[7] !== 1'b1 || hist[8] !== 1'b0) begin
         bad++; $display("FAIL pulse_clear: edge7=%b edge8=%b, required 1 0", hist[7], hist[8]);
      end
      cnt_h = 0;
      for (int k = 1; k < 30; k++) if (hist[k]) cnt_h++;
      total++;
      if (cnt_h !== 5) begin
         bad++; $display("FAIL pulse_clear_len: high=%0d, required 5", cnt_h);
      end
      model_bits[1] = 1'b0;
      total++;
      if (bits !== model_bits) begin
         bad++; $display("FAIL pulse_others: got %b, required %b", bits, model_bits);
      end
   endtask

   task automatic test_reset_mid_pulse;
      logic seen_high;
      seen_high = 1'b0;
      @(posedge clk); #1;
      addr = make_addr(4'h1, 4'h2, 7'd1);
      ti_cru_out = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      ti_cru_clk = 1'b0;
      exp_q.push_back({1'b1, 7'd1});
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk); #1;
         if (k == 3) ti_cru_clk = 1'b1;
         if (k == 5) reset = 1'b1;
         if (k == 6) reset = 1'b0;
         @(negedge clk);
         if (k == 4) seen_high = bits[1];
      end
      total++;
      if (seen_high !== 1'b1) begin
         bad++; $display("FAIL midpulse_active: bits[1]=%b before reset, required 1", seen_high);
      end
      total++;
      if (bits !== RST_V || wr_strobe !== 1'b0) begin
         bad++; $display("FAIL midpulse_reset: bits=%b strobe=%b, required %b 0", bits, wr_strobe, RST_V);
      end
      model_bits = RST_V;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         total++;
         if (bits !== RST_V || wr_strobe !== 1'b0) begin
            bad++; $display("FAIL midpulse_after: cycle %0d bits=%b strobe=%b, required %b 0", c, bits, wr_strobe, RST_V);
         end
      end
   endtask

   task automatic test_back_to_back;
      cru_write(4'h1, 4'h2, 7'd0, 1'b0, 1'b1);
      cru_write(4'h1, 4'h2, 7'd3, 1'b1, 1'b1);
      cru_write(4'h1, 4'h2, 7'd0, 1'b1, 1'b1);
      cru_write(4'h1, 4'h2, 7'd2, 1'b0, 1'b1);
      @(negedge clk);
      total++;
      if (bits !== model_bits) begin
         bad++; $display("FAIL b2b_bits: got %b, required %b", bits, model_bits);
      end
   endtask

   task automatic test_readback;
      logic [6:0] bad_idx[3];
      logic [3:0] bad_base[3];
      logic [3:0] bad_top[3];
      bad_idx  = '{7'd5, 7'd0, 7'd1};
      bad_base = '{4'h2, 4'h3, 4'h2};
      bad_top  = '{4'h1, 4'h1, 4'h0};
      for (int i = 0; i < NB; i++) begin
         @(negedge clk);
         addr = make_addr(4'h1, 4'h2, 7'(i));
         #1;
`ifdef CRUBITS_READBACK_EN
         total++;
         if (cru_in_oe !== 1'b1 || ti_cru_in !== model_bits[i]) begin
            bad++; $display("FAIL readback_hit: idx %0d oe=%b in=%b, required 1 %b", i, cru_in_oe, ti_cru_in, model_bits[i]);
         end
`else
         total++;
         if (cru_in_oe !== 1'b0 || ti_cru_in !== 1'b0) begin
            bad++; $display("FAIL readback_off: idx %0d oe=%b in=%b, required 0 0", i, cru_in_oe, ti_cru_in);
         end
`endif
      end
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         addr = make_addr(bad_top[j], bad_base[j], bad_idx[j]);
         #1;
         total++;
         if (cru_in_oe !== 1'b0 || ti_cru_in !== 1'b0) begin
            bad++; $display("FAIL readback_miss: case %0d oe=%b in=%b, required 0 0", j, cru_in_oe, ti_cru_in);
         end
      end
   endtask

   task automatic test_drain;
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++; $display("FAIL drain: %0d predicted writes never strobed, required 0", exp_q.size());
      end
      exp_q.delete();
   endtask

   initial begin
      test_reset();
      test_basic_write();
      test_rejected();
      test_pulse();
      test_reset_mid_pulse();
      test_back_to_back();
      test_readback();
      test_drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
